// File: rtl/btn_event_encoder.sv
// -----------------------------------------------------------------------------
// btn_event_encoder
//
// Conditions N_BTN raw push-buttons into clean press events for the calculator
// core. Each button is synchronised (two flops), debounced (a level only flips
// after DEBOUNCE_CYCLES consecutive disagreeing samples) and rising-edge
// detected into a pending bit. Pending presses are drained one at a time,
// lowest index first, through a valid/ready output register.
//
// Ports:
//   clk        system clock, all state on the rising edge
//   rst        asynchronous active-low reset
//   btn_raw    raw button pins (bit 0 = B1), asynchronous to clk
//   evt_ready  consumer accepts the presented event this cycle
//   evt_valid  an event is held on evt_code
//   evt_code   button number 1..N_BTN, 0 whenever evt_valid = 0
//   btn_level  debounced stable level per button
//   overrun    one-cycle pulse when a press merges into a pending press
// -----------------------------------------------------------------------------
module btn_event_encoder #(
  parameter int N_BTN           = 9,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic             evt_ready,
  output logic             evt_valid,
  output logic [3:0]       evt_code,
  output logic [N_BTN-1:0] btn_level,
  output logic             overrun
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_BTN-1:0] sync1;
  logic [N_BTN-1:0] sync2;
  logic [CNT_W-1:0] cnt [N_BTN];
  logic [N_BTN-1:0] flip;
  logic [N_BTN-1:0] rise;
  logic [N_BTN-1:0] pending;
  logic [N_BTN-1:0] load_mask;
  logic [3:0]       win_idx;
  logic             any_pending;
  logic             load;

  // Two-flop synchroniser; only sync2 is trusted downstream.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, exactly like the hardware; blocking here would chain
  // sync1 straight into sync2 in a single cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  // A level flips on the edge that would complete the DEBOUNCE_CYCLES-th
  // consecutive disagreeing sample.
  // NOTE: every always_comb output gets a value on every path (here via the
  // loop covering all bits, below via an explicit default) so no latch is
  // inferred.
  always_comb begin
    for (int i = 0; i < N_BTN; i++) begin
      flip[i] = (sync2[i] != btn_level[i]) && (cnt[i] == CNT_LAST);
    end
  end

  assign rise = flip & ~btn_level;

  // NOTE: the counter array is a bank of flops, not a RAM, so resetting it is
  // cheap and required: a reset mid-debounce must not resume a stale count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_BTN; i++) begin
        cnt[i] <= '0;
      end
      btn_level <= '0;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        if (sync2[i] == btn_level[i] || flip[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
      btn_level <= btn_level ^ flip;
    end
  end

  // Fixed priority: scanning downwards leaves the lowest pending index.
  always_comb begin
    win_idx = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (pending[i]) begin
        win_idx = 4'(i);
      end
    end
  end

  assign any_pending = |pending;
  assign load        = (!evt_valid || evt_ready) && any_pending;
  assign load_mask   = load ? (N_BTN'(1) << win_idx) : '0;

  // A rise arriving on the edge its own pending bit is loaded re-arms the bit
  // (set wins) and is a fresh press, not an overrun.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending   <= '0;
      evt_valid <= 1'b0;
      evt_code  <= '0;
      overrun   <= 1'b0;
    end else begin
      pending <= (pending & ~load_mask) | rise;
      overrun <= |(rise & pending & ~load_mask);
      if (load) begin
        evt_valid <= 1'b1;
        evt_code  <= win_idx + 4'd1;
      end else if (evt_valid && evt_ready) begin
        evt_valid <= 1'b0;
        evt_code  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_btn_event_encoder.sv
// -----------------------------------------------------------------------------
// tb_btn_event_encoder
//
// Directed bench for btn_event_encoder with DEBOUNCE_CYCLES = 4. A behavioural
// model (sample delay, disagreement streaks, a pending set drained lowest
// first) is stepped on every rising edge and compared with the DUT on every
// falling edge. Literal expectations pin the model at key points.
//
// Edge numbering in the directed tests: inputs change 1 time unit after a
// rising edge; the next rising edge is "edge 0". A value updated by edge n is
// visible from edge n + 1 time unit onwards.
// -----------------------------------------------------------------------------
module tb_btn_event_encoder;

  localparam int N  = 9;
  localparam int DB = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] btn_raw;
  logic         evt_ready;
  logic         evt_valid;
  logic [3:0]   evt_code;
  logic [N-1:0] btn_level;
  logic         overrun;

  btn_event_encoder #(
    .N_BTN(N), .DEBOUNCE_CYCLES(DB), .CNT_W(3)
  ) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw), .evt_ready(evt_ready),
    .evt_valid(evt_valid), .evt_code(evt_code), .btn_level(btn_level),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic [N-1:0] m_s1 = '0, m_s2 = '0, m_level = '0, m_pend = '0, m_rises;
  int           m_streak [N];
  logic         m_valid = 1'b0, m_over = 1'b0;
  logic [3:0]   m_code = '0;
  int           m_win, m_taken;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_s1 = '0; m_s2 = '0; m_level = '0; m_pend = '0;
      m_valid = 1'b0; m_code = '0; m_over = 1'b0;
      for (int i = 0; i < N; i++) m_streak[i] = 0;
    end else begin
      // Debounce: a level follows the synchronised input once it has
      // disagreed for DB samples in a row.
      m_rises = '0;
      for (int i = 0; i < N; i++) begin
        if (m_s2[i] != m_level[i]) begin
          m_streak[i] = m_streak[i] + 1;
          if (m_streak[i] == DB) begin
            m_level[i]  = ~m_level[i];
            m_streak[i] = 0;
            if (m_level[i]) m_rises[i] = 1'b1;
          end
        end else begin
          m_streak[i] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = btn_raw;
      // Output: lowest pending button wins when the register is free.
      m_win = -1;
      for (int i = N - 1; i >= 0; i--) if (m_pend[i]) m_win = i;
      m_taken = -1;
      m_over  = 1'b0;
      if ((!m_valid || evt_ready) && m_win >= 0) begin
        m_valid = 1'b1; m_code = 4'(m_win + 1); m_taken = m_win;
      end else if (m_valid && evt_ready) begin
        m_valid = 1'b0; m_code = '0;
      end
      for (int i = 0; i < N; i++) begin
        if (m_rises[i]) begin
          if (m_pend[i] && i != m_taken) m_over = 1'b1;
          m_pend[i] = 1'b1;
        end else if (i == m_taken) begin
          m_pend[i] = 1'b0;
        end
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("evt_valid", evt_valid, m_valid);
      check("evt_code",  evt_code,  m_code);
      check("btn_level", btn_level, m_level);
      check("overrun",   overrun,   m_over);
    end
  end

  // ---------------- monitors (feed literal checks) ----------------
  int acc[$];
  int ovr_n = 0;
  always @(posedge clk) if (rst === 1'b1 && evt_valid === 1'b1 && evt_ready === 1'b1) acc.push_back(int'(evt_code));
  always @(negedge clk) if (overrun === 1'b1) ovr_n++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_acc(input string name, input int base, input int exp_n, input int c0, input int c1);
    check({name, "_count"}, acc.size() - base, exp_n);
    if (exp_n > 0 && acc.size() > base)     check({name, "_first"},  acc[base], c0);
    if (exp_n > 1 && acc.size() > base + 1) check({name, "_second"}, acc[base + 1], c1);
  endtask

  int base, ovr_base;

  initial begin
    rst = 1'b1; btn_raw = '0; evt_ready = 1'b0;
    #1 rst = 1'b0;
    chk_en = 1'b1;
    repeat (2) tick();
    check("reset_valid", evt_valid, 0);
    check("reset_level", btn_level, 0);
    rst = 1'b1;
    repeat (3) tick();

    // Test 1: asynchronous reset while an event is held and a count is running.
    base = acc.size();
    btn_raw[2] = 1'b1;
    repeat (7) tick();
    check("t1_pre_valid", evt_valid, 1);
    check("t1_pre_code",  evt_code, 3);
    btn_raw[2] = 1'b0;
    repeat (3) tick();
    #3 rst = 1'b0;
    #1;
    check("t1_rst_valid", evt_valid, 0);
    check("t1_rst_code",  evt_code, 0);
    check("t1_rst_level", btn_level, 0);
    check("t1_rst_ovr",   overrun, 0);
    tick();
    rst = 1'b1;
    repeat (10) tick();
    check("t1_post_valid", evt_valid, 0);
    check_acc("t1", base, 0, 0, 0);

    // Test 2: clean press of B4 with the consumer always ready.
    base = acc.size();
    evt_ready = 1'b1;
    btn_raw[3] = 1'b1;
    repeat (5) tick();                      // after edge 4
    check("t2_level_e4", btn_level[3], 0);
    tick();                                 // after edge 5
    check("t2_level_e5", btn_level[3], 1);
    check("t2_valid_e5", evt_valid, 0);
    tick();                                 // after edge 6
    check("t2_valid_e6", evt_valid, 1);
    check("t2_code_e6",  evt_code, 4);
    tick();                                 // after edge 7
    check("t2_valid_e7", evt_valid, 0);
    check("t2_code_e7",  evt_code, 0);
    btn_raw[3] = 1'b0;
    repeat (8) tick();
    check_acc("t2", base, 1, 4, 0);

    // Test 3: B1 bounces (2 cycles per level) for 12 cycles, then holds high.
    base = acc.size(); ovr_base = ovr_n;
    for (int j = 0; j < 12; j++) begin
      btn_raw[0] = ((j % 4) < 2);
      tick();
    end
    btn_raw[0] = 1'b1;
    repeat (12) tick();
    check("t3_level", btn_level[0], 1);
    check("t3_ovr", ovr_n - ovr_base, 0);
    check_acc("t3", base, 1, 1, 0);
    btn_raw[0] = 1'b0;
    repeat (8) tick();

    // Test 4: B2 and B7 together, consumer stalled, then two ready pulses.
    base = acc.size();
    evt_ready = 1'b0;
    btn_raw[1] = 1'b1; btn_raw[6] = 1'b1;
    repeat (7) tick();
    check("t4_code_a", evt_code, 2);
    repeat (3) tick();
    check("t4_code_hold", evt_code, 2);
    evt_ready = 1'b1; tick(); evt_ready = 1'b0;
    check("t4_valid_b", evt_valid, 1);
    check("t4_code_b",  evt_code, 7);
    tick();
    check("t4_code_b_hold", evt_code, 7);
    evt_ready = 1'b1; tick(); evt_ready = 1'b0;
    check("t4_valid_end", evt_valid, 0);
    check("t4_code_end",  evt_code, 0);
    check_acc("t4", base, 2, 2, 7);
    btn_raw = '0;
    repeat (8) tick();

    // Test 5: B5 held undelivered while B1 is pressed twice -> one overrun.
    base = acc.size(); ovr_base = ovr_n;
    btn_raw[4] = 1'b1;
    repeat (7) tick();
    check("t5_code5", evt_code, 5);
    btn_raw[0] = 1'b1; repeat (6) tick();
    btn_raw[0] = 1'b0; repeat (6) tick();
    btn_raw[0] = 1'b1; repeat (8) tick();
    check("t5_ovr", ovr_n - ovr_base, 1);
    evt_ready = 1'b1;
    tick();
    check("t5_code1", evt_code, 1);
    tick();
    check("t5_valid_end", evt_valid, 0);
    check_acc("t5", base, 2, 5, 1);
    btn_raw = '0;
    repeat (8) tick();

    // Debounce boundary on B9: DB-1 high samples is a glitch, DB is a press.
    base = acc.size();
    btn_raw[8] = 1'b1; repeat (DB - 1) tick();
    btn_raw[8] = 1'b0; repeat (10) tick();
    check("t6_glitch_level", btn_level[8], 0);
    check_acc("t6_glitch", base, 0, 0, 0);
    btn_raw[8] = 1'b1; repeat (DB) tick();
    btn_raw[8] = 1'b0; repeat (10) tick();
    check_acc("t6_press", base, 1, 9, 0);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
